regread_stage: RTL and testbench

Register-read stage sitting directly between decode and execute_stage. Holds the 16x32 architectural register file and one pipeline register of decoded-instruction state. Drives the rr_* bundle consumed by execute, resolving operands through bypass from execute's forward port and writeback. Honours execute's stall/flush, propagates stall upstream, and inserts bubbles.

---
 rtl/regread_stage.sv | 133 +++++++++++++
 tb/tb_regread_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regread_stage.sv
// Register-read stage between decode and execute.
// Holds the architectural register file and one pipeline register of decoded state.
// Operands are resolved every cycle from the captured rs/rt through the execute-forward and writeback bypass paths.
module regread_stage #(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 4,
  parameter int RESET_REGFILE = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              dec_valid,
  input  logic [31:0]       dec_pc,
  input  logic [5:0]        dec_op,
  input  logic [7:0]        dec_altop,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic [31:0]       dec_imm32,
  input  logic [31:0]       dec_pc_inc,
  input  logic              dec_next_is_cont,
  input  logic [31:0]       dec_predicted_pc,
  input  logic              exec_stall,
  input  logic              exec_flush,
  input  logic [REG_AW-1:0] exec_of_reg,
  input  logic [DATA_W-1:0] exec_of_val,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_val,
  output logic              rr_stall,
  output logic [31:0]       rr_pc,
  output logic [5:0]        rr_op,
  output logic [7:0]        rr_altop,
  output logic [REG_AW-1:0] rr_rd,
  output logic [REG_AW-1:0] rr_rs,
  output logic [REG_AW-1:0] rr_rt,
  output logic [DATA_W-1:0] rr_rs_val,
  output logic [DATA_W-1:0] rr_rt_val,
  output logic [31:0]       rr_imm32,
  output logic [31:0]       rr_pc_inc,
  output logic              rr_next_is_cont,
  output logic [31:0]       rr_predicted_pc
);

  localparam int NREG = 2 ** REG_AW;

  // Architectural registers; entry 0 exists but is never read (r0 is hardwired to zero).
  logic [DATA_W-1:0] r_regfile [NREG];

  // Captured instruction state presented to execute.
  logic [31:0]       r_pc;
  logic [5:0]        r_op;
  logic [7:0]        r_altop;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [31:0]       r_imm32;
  logic [31:0]       r_pc_inc;
  logic              r_next_is_cont;
  logic [31:0]       r_predicted_pc;

  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;

  // Operand lookup: r0 is zero, then the youngest producer (execute) wins over writeback, then the file.
  function automatic logic [DATA_W-1:0] resolve(input logic [REG_AW-1:0] idx);
    if (idx == '0)
      return '0;
    else if (idx == exec_of_reg)
      return exec_of_val;
    else if (idx == wb_rd)
      return wb_val;
    else
      return r_regfile[idx];
  endfunction

  // Writeback port; writes to r0 are discarded, optional clear on reset.
  always_ff @(posedge i_clk) begin
    if (i_reset && (RESET_REGFILE != 0)) begin
      for (int i = 0; i < NREG; i++)
        r_regfile[i] <= '0;
    end else if (wb_rd != '0) begin
      r_regfile[wb_rd] <= wb_val;
    end
  end

  // Pipeline register: reset > flush (bubble) > stall (hold) > valid capture > bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset || exec_flush || (!exec_stall && !dec_valid)) begin
      r_pc           <= '0;
      r_op           <= '0;
      r_altop        <= '0;
      r_rd           <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_imm32        <= '0;
      r_pc_inc       <= '0;
      r_next_is_cont <= 1'b0;
      r_predicted_pc <= '0;
    end else if (!exec_stall) begin
      r_pc           <= dec_pc;
      r_op           <= dec_op;
      r_altop        <= dec_altop;
      r_rd           <= dec_rd;
      r_rs           <= dec_rs;
      r_rt           <= dec_rt;
      r_imm32        <= dec_imm32;
      r_pc_inc       <= dec_pc_inc;
      r_next_is_cont <= dec_next_is_cont;
      r_predicted_pc <= dec_predicted_pc;
    end
  end

  // Operands are re-resolved every cycle so values produced during a stall reach execute without re-issue.
  always_comb begin
    w_rs_val = resolve(r_rs);
    w_rt_val = resolve(r_rt);
  end

  // A flush squashes the held instruction, so decode need not hold in that case.
  assign rr_stall        = exec_stall && !exec_flush;
  assign rr_pc           = r_pc;
  assign rr_op           = r_op;
  assign rr_altop        = r_altop;
  assign rr_rd           = r_rd;
  assign rr_rs           = r_rs;
  assign rr_rt           = r_rt;
  assign rr_rs_val       = w_rs_val;
  assign rr_rt_val       = w_rt_val;
  assign rr_imm32        = r_imm32;
  assign rr_pc_inc       = r_pc_inc;
  assign rr_next_is_cont = r_next_is_cont;
  assign rr_predicted_pc = r_predicted_pc;

endmodule

// File: tb/tb_regread_stage.sv
// Testbench for regread_stage: directed scenarios followed by random traffic,
// compared against a behavioural model of the stage.
module tb_regread_stage;

  logic        clk;
  logic        reset;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [5:0]  dec_op;
  logic [7:0]  dec_altop;
  logic [3:0]  dec_rd, dec_rs, dec_rt;
  logic [31:0] dec_imm32, dec_pc_inc, dec_predicted_pc;
  logic        dec_next_is_cont;
  logic        exec_stall, exec_flush;
  logic [3:0]  exec_of_reg;
  logic [31:0] exec_of_val;
  logic [3:0]  wb_rd;
  logic [31:0] wb_val;
  logic        rr_stall;
  logic [31:0] rr_pc;
  logic [5:0]  rr_op;
  logic [7:0]  rr_altop;
  logic [3:0]  rr_rd, rr_rs, rr_rt;
  logic [31:0] rr_rs_val, rr_rt_val, rr_imm32, rr_pc_inc, rr_predicted_pc;
  logic        rr_next_is_cont;

  int checks = 0;
  int errors = 0;

  regread_stage dut (
    .i_clk(clk), .i_reset(reset), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_op(dec_op), .dec_altop(dec_altop), .dec_rd(dec_rd), .dec_rs(dec_rs),
    .dec_rt(dec_rt), .dec_imm32(dec_imm32), .dec_pc_inc(dec_pc_inc),
    .dec_next_is_cont(dec_next_is_cont), .dec_predicted_pc(dec_predicted_pc),
    .exec_stall(exec_stall), .exec_flush(exec_flush), .exec_of_reg(exec_of_reg),
    .exec_of_val(exec_of_val), .wb_rd(wb_rd), .wb_val(wb_val),
    .rr_stall(rr_stall), .rr_pc(rr_pc), .rr_op(rr_op), .rr_altop(rr_altop),
    .rr_rd(rr_rd), .rr_rs(rr_rs), .rr_rt(rr_rt), .rr_rs_val(rr_rs_val),
    .rr_rt_val(rr_rt_val), .rr_imm32(rr_imm32), .rr_pc_inc(rr_pc_inc),
    .rr_next_is_cont(rr_next_is_cont), .rr_predicted_pc(rr_predicted_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction currently held for execute, and the register contents.
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [7:0]  altop;
    logic [3:0]  rd, rs, rt;
    logic [31:0] imm32, pc_inc;
    logic        next_is_cont;
    logic [31:0] predicted_pc;
  } instr_t;

  instr_t      m_instr;
  logic [31:0] m_rf [16];

  function automatic logic [31:0] ref_operand(input logic [3:0] r);
    if (r == 4'd0) return 32'd0;
    if (r == exec_of_reg) return exec_of_val;
    if (r == wb_rd) return wb_val;
    return m_rf[r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: compare outputs against the model (inputs already applied), then advance the model at the edge.
  task automatic step(input bit do_check);
    #1;
    if (do_check) begin
      chk("rr_stall", {31'd0, rr_stall}, {31'd0, exec_stall && !exec_flush});
      chk("rr_pc", rr_pc, m_instr.pc);
      chk("rr_op", {26'd0, rr_op}, {26'd0, m_instr.op});
      chk("rr_altop", {24'd0, rr_altop}, {24'd0, m_instr.altop});
      chk("rr_rd", {28'd0, rr_rd}, {28'd0, m_instr.rd});
      chk("rr_rs", {28'd0, rr_rs}, {28'd0, m_instr.rs});
      chk("rr_rt", {28'd0, rr_rt}, {28'd0, m_instr.rt});
      chk("rr_rs_val", rr_rs_val, ref_operand(m_instr.rs));
      chk("rr_rt_val", rr_rt_val, ref_operand(m_instr.rt));
      chk("rr_imm32", rr_imm32, m_instr.imm32);
      chk("rr_pc_inc", rr_pc_inc, m_instr.pc_inc);
      chk("rr_next_is_cont", {31'd0, rr_next_is_cont}, {31'd0, m_instr.next_is_cont});
      chk("rr_predicted_pc", rr_predicted_pc, m_instr.predicted_pc);
    end
    @(posedge clk);
    if (reset) begin
      m_instr = '0;
      for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    end else begin
      if (wb_rd != 4'd0) m_rf[wb_rd] = wb_val;
      if (exec_flush) m_instr = '0;
      else if (exec_stall) m_instr = m_instr;
      else if (dec_valid)
        m_instr = '{pc: dec_pc, op: dec_op, altop: dec_altop, rd: dec_rd, rs: dec_rs,
                    rt: dec_rt, imm32: dec_imm32, pc_inc: dec_pc_inc,
                    next_is_cont: dec_next_is_cont, predicted_pc: dec_predicted_pc};
      else m_instr = '0;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    reset = 0; dec_valid = 0; exec_stall = 0; exec_flush = 0;
    exec_of_reg = 0; exec_of_val = 0; wb_rd = 0; wb_val = 0;
  endtask

  task automatic issue(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    dec_valid = 1; dec_rd = rd; dec_rs = rs; dec_rt = rt;
    dec_pc = $urandom; dec_op = 6'($urandom_range(1, 63)); dec_altop = 8'($urandom);
    dec_imm32 = $urandom; dec_pc_inc = dec_pc + 32'd4;
    dec_next_is_cont = 1'($urandom); dec_predicted_pc = $urandom;
  endtask

  function automatic logic [3:0] pick_reg();
    // Bias towards a few registers so bypass collisions are common.
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    m_instr = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    quiet();
    issue(4'd1, 4'd2, 4'd3);
    dec_op = 6'h08;  // ADDI-like instruction held at decode throughout reset
    reset = 1;
    step(0);
    step(1);
    // After reset every register reads zero.
    quiet();
    for (int i = 1; i < 16; i++) begin
      issue(4'd0, 4'(i), 4'(i));
      step(1);
    end
    quiet();
    step(1);
    step(1);

    // Basic pass: write r3, then read it.
    wb_rd = 4'd3; wb_val = 32'h1234;
    step(1);
    quiet(); issue(4'd5, 4'd3, 4'd0);
    step(1);
    quiet();
    step(1);

    // Bypass priority on r4: file=1, wb=2, exec=3.
    wb_rd = 4'd4; wb_val = 32'd1;
    step(1);
    quiet(); issue(4'd6, 4'd4, 4'd4);
    step(1);
    quiet(); exec_stall = 1;
    wb_rd = 4'd4; wb_val = 32'd2; exec_of_reg = 4'd4; exec_of_val = 32'd3;
    step(1);
    exec_of_reg = 4'd0;
    step(1);
    wb_rd = 4'd0;
    step(1);

    // Stall refresh: rs=7 held while execute produces 0xDEAD on the second stall cycle.
    quiet(); issue(4'd8, 4'd7, 4'd2);
    step(1);
    dec_valid = 1; dec_rs = 4'd9; exec_stall = 1;
    step(1);
    exec_of_reg = 4'd7; exec_of_val = 32'hDEAD;
    step(1);
    exec_stall = 0; exec_of_reg = 4'd0;
    step(1);
    quiet();
    step(1);

    // Flush wins over stall and valid.
    issue(4'd10, 4'd1, 4'd2); dec_next_is_cont = 1;
    step(1);
    exec_flush = 1; exec_stall = 1;
    step(1);
    quiet();
    step(1);

    // r0 protection: writes and forwards to r0 are ignored.
    wb_rd = 4'd0; wb_val = 32'hFFFF_FFFF; exec_of_reg = 4'd0; exec_of_val = 32'hFFFF_FFFF;
    issue(4'd0, 4'd0, 4'd0);
    step(1);
    step(1);

    // Reset in the middle of a stall and flush.
    issue(4'd2, 4'd3, 4'd4);
    step(1);
    exec_stall = 1; exec_flush = 1; reset = 1;
    step(1);
    quiet();
    step(1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 59) == 0);
      exec_flush  = ($urandom_range(0, 9) == 0);
      exec_stall  = ($urandom_range(0, 3) == 0);
      exec_of_reg = pick_reg();
      exec_of_val = $urandom;
      wb_rd       = pick_reg();
      wb_val      = $urandom;
      if ($urandom_range(0, 4) != 0) issue(pick_reg(), pick_reg(), pick_reg());
      else dec_valid = 0;
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
